gcd_client: RTL and testbench
=============================

// Module: gcd_client
// PURPOSE
//  Initiator side of the GCD request/response streams. Takes one batch command,
//  issues a sequence of {a,b} requests to a GCD unit, consumes the 16-bit
//  responses, and returns one summary (sum, max of the GCDs) per command.
//  Sits between a control master and hw_gcd_GcdUnit, with several requests in flight.
// PARAMETERS
//  p_max_outstanding  4  max requests issued but not yet answered (1..15)
// PORTS
//  clk     in   1   clock
//  rst     in   1   synchronous, active-high reset
//  cmd     StreamIntf sink    64  {a0[63:48], b0[47:32], step_a[31:24], step_b[23:16], count[15:0]}
//  req     StreamIntf source  32  {a[31:16], b[15:0]}; connects to GcdUnit istream
//  resp    StreamIntf sink    16  gcd result; connects to GcdUnit ostream
//  result  StreamIntf source  48  {sum[47:16], max[15:0]}
// BEHAVIOUR
//  - Handshake: a transfer fires in the cycle where val & rdy are both high.
//    Once val is raised, msg stays stable and val stays high until the transfer fires.
//  - Reset: state=IDLE, cmd.rdy=1, req.val=0, resp.rdy=0, result.val=0.
//    issued, received, outstanding, sum and max are all 0.
//  - FSM: IDLE -> RUN on cmd fire; RUN -> DONE when received==count; DONE -> IDLE on result fire.
//  - IDLE: cmd.rdy=1, all other val/rdy low. On cmd fire, latch the cmd fields and
//    set a_cur=a0, b_cur=b0, issued=received=outstanding=sum=max=0.
//    count==0 goes RUN->DONE in the next cycle with no requests issued; result={0,0}.
//  - RUN:
//    - req.val=(issued<count)&&(outstanding<p_max_outstanding); req.msg={a_cur,b_cur}.
//      The first request is visible in the cycle after cmd fires.
//    - On req fire: a_cur+=step_a and b_cur+=step_b (zero-extended, wrap mod 2^16); issued++.
//    - resp.rdy=1. On resp fire: sum+=resp.msg (32-bit, cannot overflow for count<=65535);
//      max=max(max,resp.msg); received++.
//    - outstanding: +1 on req fire only, -1 on resp fire only, unchanged if both fire.
//      It never exceeds p_max_outstanding.
//    - Responses arrive in request order (GcdUnit is in-order); no tagging.
//  - DONE: result.val=1, result.msg={sum,max}; cmd.rdy=0 and resp.rdy=0.
//    Result holds stable under backpressure.
//  - cmd.rdy is 0 in RUN and DONE: exactly one command per summary.
//  - resp.rdy is 0 in IDLE and DONE, so a stray response stalls in the GCD unit, never dropped.
//  - Reset mid-operation: reset values take effect in the next cycle and partial
//    results are discarded. GCD unit must share rst.
//  - Counters are 16-bit; outstanding is $clog2(p_max_outstanding+1) bits.
// STRUCTURE
//  - gcd_pkg: typedefs gcd_cmd_t (64b packed), gcd_req_t (32b), gcd_resp_t (16b),
//    gcd_result_t (48b); state enum gcd_client_state_e {IDLE, RUN, DONE}.
//  - Sub-module gcd_client_credit: up/down counter with inc/dec/full outputs,
//    parameterized by p_max_outstanding.
//  - Provides a trace() function (state, issued/received, outstanding) for bench linetracing.
// TESTING (bench: gcd_client + hw_gcd_GcdUnit; suites at stream delays 0/0, 3/0, 0/3, 3/3)
//  1. cmd a0=15,b0=5,step 0/0,count=1 -> req {15,5}; result sum=5,max=5.
//  2. a0=12,b0=18,step_a=6,step_b=0,count=3 -> reqs (12,18),(18,18),(24,18);
//     gcds 6,18,6; result sum=30,max=18.
//  3. count=0 -> no req fires; result {0,0} two cycles after cmd fire;
//     cmd.rdy returns once result fires.
//  4. p_max_outstanding=4, count=10, resp source stalled -> exactly 4 req fires, then
//     req.val=0; each released response enables exactly one more request.
//  5. Wrap: a0=0xFFFF,step_a=1,b0=4,step_b=0,count=2 -> reqs (65535,4),(0,4);
//     result sum=5,max=4.
//  6. result.rdy low for 5 cycles -> result.msg stable, cmd.rdy=0.
//     rst asserted mid-RUN -> reset values next cycle; a fresh cmd then completes correctly.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared message types, client states and a linetrace helper
package gcd_pkg;
  typedef struct packed {
    logic [15:0] a0;
    logic [15:0] b0;
    logic [7:0]  step_a;
    logic [7:0]  step_b;
    logic [15:0] count;
  } gcd_cmd_t;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } gcd_req_t;
  typedef logic [15:0] gcd_resp_t;
  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] max;
  } gcd_result_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} gcd_client_state_e;
  function automatic string trace(input logic [1:0] st, input logic [15:0] issued, input logic [15:0] received, input int outstanding);
    return $sformatf("%s iss=%0d rcv=%0d out=%0d", st == IDLE ? "IDLE" : st == RUN ? "RUN " : "DONE", issued, received, outstanding);
  endfunction
endpackage

// File: rtl/gcd_client_if.sv
// gcd_client_if: val/rdy stream; a transfer fires when val and rdy are both high
interface gcd_client_if #(parameter int W = 32) ();
  logic         val;
  logic         rdy;
  logic [W-1:0] msg;
  modport master (output val, output msg, input rdy);
  modport slave (input val, input msg, output rdy);
endinterface

// File: rtl/gcd_client_credit.sv
// gcd_client_credit: in-flight request counter, saturating issue at p_max_outstanding
module gcd_client_credit #(
  parameter int p_max_outstanding = 4,
  localparam int OW = $clog2(p_max_outstanding + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [OW-1:0] count,
  output logic          full
);
  assign full = count == OW'(p_max_outstanding);
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (inc && !dec) count <= count + OW'(1);
    else if (dec && !inc) count <= count - OW'(1);
  end
endmodule

// File: rtl/gcd_client.sv
// gcd_client: turns one batch command into pipelined GCD requests and returns {sum,max}
module gcd_client
  import gcd_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input logic          clk,
  input logic          rst,
  gcd_client_if.slave  cmd,
  gcd_client_if.master req,
  gcd_client_if.slave  resp,
  gcd_client_if.master result
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN = RUN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam int OW = $clog2(p_max_outstanding + 1);
  logic [1:0]    state;
  gcd_cmd_t      nc;
  gcd_resp_t     rmsg;
  logic [7:0]    step_a, step_b;
  logic [15:0]   count, a_cur, b_cur, issued, received, mx;
  logic [31:0]   sum;
  logic [OW-1:0] outstanding;
  logic          full, cmd_fire, req_fire, resp_fire, result_fire;
  assign nc = cmd.msg;
  assign rmsg = resp.msg;
  assign cmd.rdy = state == ST_IDLE;
  assign req.val = state == ST_RUN && issued < count && !full;
  assign req.msg = gcd_req_t'{a: a_cur, b: b_cur};
  assign resp.rdy = state == ST_RUN;
  assign result.val = state == ST_DONE;
  assign result.msg = gcd_result_t'{sum: sum, max: mx};
  assign cmd_fire = cmd.val && cmd.rdy;
  assign req_fire = req.val && req.rdy;
  assign resp_fire = resp.val && resp.rdy;
  assign result_fire = result.val && result.rdy;
  gcd_client_credit #(.p_max_outstanding(p_max_outstanding)) credit (
    .clk(clk),
    .rst(rst),
    .clr(cmd_fire),
    .inc(req_fire),
    .dec(resp_fire),
    .count(outstanding),
    .full(full)
  );
  // cmd fires only in IDLE and req/resp only in RUN, so the updates below never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      {step_a, step_b, count, a_cur, b_cur, issued, received, mx, sum} <= '0;
    end else begin
      state <= state == ST_IDLE && cmd_fire ? ST_RUN :
               state == ST_RUN && received == count ? ST_DONE :
               state == ST_DONE && result_fire ? ST_IDLE : state;
      if (cmd_fire) begin
        {a_cur, b_cur, step_a, step_b, count} <= nc;
        {issued, received, mx, sum} <= '0;
      end
      if (req_fire) begin
        a_cur <= a_cur + {8'd0, step_a};
        b_cur <= b_cur + {8'd0, step_b};
        issued <= issued + 16'd1;
      end
      if (resp_fire) begin
        sum <= sum + {16'd0, rmsg};
        mx <= rmsg > mx ? rmsg : mx;
        received <= received + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed checks of gcd_client with a bench-modelled in-order GCD unit
module tb_gcd_client;
  import gcd_pkg::*;
  logic clk = 0, rst = 1;
  int n_assert = 0, n_fail = 0;
  logic [15:0] exp_a[$], exp_b[$];
  always #5 clk = ~clk;
  gcd_client_if #(64) cmd_if ();
  gcd_client_if #(32) req_if ();
  gcd_client_if #(16) resp_if ();
  gcd_client_if #(48) res_if ();
  gcd_client #(.p_max_outstanding(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd_if),
    .req(req_if),
    .resp(resp_if),
    .result(res_if)
  );
  function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send_cmd(input logic [15:0] a0, input logic [15:0] b0, input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] cnt);
    int g = 0;
    cmd_if.val = 1;
    cmd_if.msg = {a0, b0, sa, sb, cnt};
    while (!cmd_if.rdy && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) chk("cmd_rdy_timeout", 0, 1);
    step();
    cmd_if.val = 0;
  endtask
  task automatic run_batch(input string tag, input int n, input int rdel, input int pdel, input int hold, input logic [31:0] esum, input logic [15:0] emax);
    int fires = 0, rw = 0, pw = 0, g = 0;
    logic [15:0] pend[$];
    logic [47:0] held;
    logic rf, pf;
    res_if.rdy = 0;
    while (!res_if.val && g < 2000) begin
      req_if.rdy = rw >= rdel;
      resp_if.val = pend.size() > 0 && pw >= pdel;
      resp_if.msg = pend.size() > 0 ? pend[0] : 16'd0;
      rf = req_if.val && req_if.rdy;
      pf = resp_if.val && resp_if.rdy;
      if (pf) begin
        void'(pend.pop_front());
        pw = 0;
      end else pw++;
      if (rf) begin
        if (fires < exp_a.size()) chk({tag, "_req"}, req_if.msg, {exp_a[fires], exp_b[fires]});
        pend.push_back(gcd(req_if.msg[31:16], req_if.msg[15:0]));
        fires++;
        rw = 0;
      end else rw++;
      step();
      g++;
    end
    req_if.rdy = 0;
    resp_if.val = 0;
    if (g >= 2000) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_nreq"}, fires, n);
    chk({tag, "_sum"}, res_if.msg[47:16], esum);
    chk({tag, "_max"}, res_if.msg[15:0], emax);
    held = res_if.msg;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold"}, {res_if.val, cmd_if.rdy, res_if.msg}, {2'b10, held});
    end
    res_if.rdy = 1;
    step();
    res_if.rdy = 0;
    chk({tag, "_back_idle"}, {res_if.val, cmd_if.rdy}, 2'b01);
    exp_a.delete();
    exp_b.delete();
  endtask
  task automatic chk_reset(input string tag);
    chk(tag, {cmd_if.rdy, req_if.val, resp_if.rdy, res_if.val}, 4'b1000);
    chk({tag, "_cnt"}, {dut.issued, dut.received, dut.sum, dut.mx}, '0);
  endtask
  initial begin
    int fires;
    cmd_if.val = 0;
    cmd_if.msg = '0;
    req_if.rdy = 0;
    resp_if.val = 0;
    resp_if.msg = '0;
    res_if.rdy = 0;
    step();
    step();
    rst = 0;
    chk_reset("reset");
    // single request, requests throttled by 3 cycles
    send_cmd(16'd15, 16'd5, 8'd0, 8'd0, 16'd1);
    exp_a = '{16'd15};
    exp_b = '{16'd5};
    run_batch("t1", 1, 3, 0, 0, 32'd5, 16'd5);
    // stepped a, both sides delayed
    send_cmd(16'd12, 16'd18, 8'd6, 8'd0, 16'd3);
    exp_a = '{16'd12, 16'd18, 16'd24};
    exp_b = '{16'd18, 16'd18, 16'd18};
    run_batch("t2", 3, 3, 3, 0, 32'd30, 16'd18);
    // count 0: result two cycles after cmd fire, held for 5 cycles
    send_cmd(16'd7, 16'd3, 8'd1, 8'd1, 16'd0);
    chk("t3_run", {res_if.val, req_if.val, cmd_if.rdy}, 3'b000);
    run_batch("t3", 0, 0, 0, 5, 32'd0, 16'd0);
    // outstanding limit with stalled responses
    send_cmd(16'd100, 16'd10, 8'd1, 8'd0, 16'd10);
    req_if.rdy = 1;
    fires = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_if.val) fires++;
      step();
    end
    chk("t4_stall_fires", fires, 4);
    chk("t4_stall_val", req_if.val, 0);
    $display("trace: %s", trace(dut.state, dut.issued, dut.received, int'(dut.outstanding)));
    resp_if.val = 1;
    resp_if.msg = 16'd10;
    step();
    resp_if.val = 0;
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_if.val) fires++;
      step();
    end
    chk("t4_release_fires", fires, 1);
    chk("t4_sum_partial", dut.sum, 10);
    // reset mid-RUN discards the partial batch
    rst = 1;
    step();
    rst = 0;
    req_if.rdy = 0;
    chk_reset("t6_mid_reset");
    // wrap of a_cur, responses delayed
    send_cmd(16'hFFFF, 16'd4, 8'd1, 8'd0, 16'd2);
    exp_a = '{16'hFFFF, 16'h0000};
    exp_b = '{16'd4, 16'd4};
    run_batch("t5", 2, 0, 3, 2, 32'd5, 16'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
